// File: rtl/alu1_sized_mc.sv
// Execute-stage ALU1 with 8/16/32-bit operand size, an iterative multi-cycle shifter
// and valid/ready handshakes on both the operand and the result side.
module alu1_sized_mc #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu1_op,
    input  logic [1:0]        alu1_op_size,
    input  logic [DATA_W-1:0] sr1,
    input  logic [DATA_W-1:0] sr2,
    input  logic [DATA_W-1:0] eax,
    input  logic              CF_in,
    input  logic              AF_in,
    input  logic              DF_in,
    input  logic [5:0]        ld_flag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_res1,
    output logic [5:0]        alu1_flags,
    output logic [5:0]        ld_flag_out,
    output logic              out_err
);

    localparam logic [3:0] OP_OR   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_SAL  = 4'h2;
    localparam logic [3:0] OP_SAR  = 4'h3;
    localparam logic [3:0] OP_MOV1 = 4'h4;
    localparam logic [3:0] OP_MOV2 = 4'h5;
    localparam logic [3:0] OP_ZERO = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_ADD  = 4'h9;
    localparam logic [3:0] OP_STR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_DAA  = 4'hC;

    localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic msb_n(input logic [31:0] v, input logic [1:0] sz);
        case (sz)
            2'b00:   return v[7];
            2'b01:   return v[15];
            default: return v[31];
        endcase
    endfunction

    // Bit N of a 33-bit value: the carry/borrow out of the operand msb.
    function automatic logic bit_n(input logic [32:0] v, input logic [1:0] sz);
        case (sz)
            2'b00:   return v[8];
            2'b01:   return v[16];
            default: return v[32];
        endcase
    endfunction

    function automatic logic [31:0] sext_n(input logic [31:0] v, input logic [1:0] sz);
        case (sz)
            2'b00:   return {{24{v[7]}}, v[7:0]};
            2'b01:   return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] res_q, res_d;
    logic [5:0]  flags_q, flags_d;
    logic [5:0]  ldf_q, ldf_d;
    logic        err_q, err_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] hi_q, hi_d;
    logic [1:0]  sz_q, sz_d;
    logic        sar_q, sar_d;
    logic [5:0]  ldsh_q, ldsh_d;

    // Single-cycle datapath evaluated on the live inputs at accept time
    logic [31:0] msk, a_m, b_m, ar_x, ar_y, c_res, f_val, str_step;
    logic [32:0] arith;
    logic [1:0]  f_sz;
    logic [7:0]  daa_1, daa_2;
    logic        daa_lo, daa_hi, ar_xm, ar_ym, ar_rm;
    logic        c_cf, c_pf, c_af, c_zf, c_sf, c_of, c_err, c_go_shift, c_std;
    logic [5:0]  c_flags, c_ldf;

    always_comb begin
        msk   = size_mask(alu1_op_size);
        a_m   = sr1 & msk;
        b_m   = sr2 & msk;
        ar_x  = (alu1_op == OP_CMP) ? (eax & msk) : a_m;
        ar_y  = (alu1_op == OP_INC) ? 32'd1 : ((alu1_op == OP_CMP) ? a_m : b_m);
        arith = (alu1_op == OP_CMP) ? ({1'b0, ar_x} - {1'b0, ar_y})
                                    : ({1'b0, ar_x} + {1'b0, ar_y});
        ar_xm = msb_n(ar_x, alu1_op_size);
        ar_ym = msb_n(ar_y, alu1_op_size);
        ar_rm = msb_n(arith[31:0], alu1_op_size);

        daa_lo = (eax[3:0] > 4'd9) || AF_in;
        daa_1  = daa_lo ? (eax[7:0] + 8'h06) : eax[7:0];
        daa_hi = (eax[7:0] > 8'h99) || CF_in;
        daa_2  = daa_hi ? (daa_1 + 8'h60) : daa_1;

        case (alu1_op_size)
            2'b00:   str_step = 32'd1;
            2'b01:   str_step = 32'd2;
            default: str_step = 32'd4;
        endcase

        c_res      = '0;
        f_val      = '0;
        f_sz       = alu1_op_size;
        c_cf       = 1'b0;
        c_pf       = 1'b0;
        c_af       = 1'b0;
        c_zf       = 1'b0;
        c_sf       = 1'b0;
        c_of       = 1'b0;
        c_std      = 1'b1;
        c_err      = 1'b0;
        c_go_shift = 1'b0;
        c_ldf      = ld_flag_in;

        case (alu1_op)
            OP_OR: begin
                c_res = ((sr1 | sr2) & msk) | (sr1 & ~msk);
                f_val = c_res;
            end
            OP_AND: begin
                c_res = ((sr1 & sr2) & msk) | (sr1 & ~msk);
                f_val = c_res;
            end
            OP_SAL, OP_SAR: begin
                if (sr2[4:0] == 5'd0) begin
                    c_res = sr1;
                    c_ldf = '0;
                    c_std = 1'b0;
                end else begin
                    c_go_shift = 1'b1;
                end
            end
            OP_MOV1, OP_MOV2, OP_ZERO, OP_NOT: begin
                case (alu1_op)
                    OP_MOV1: c_res = sr1;
                    OP_MOV2: c_res = sr2;
                    OP_ZERO: c_res = '0;
                    default: c_res = ~sr1;
                endcase
                // sr1 carries a packed flag image in EFLAGS bit positions
                c_std = 1'b0;
                c_cf  = sr1[0];
                c_pf  = sr1[2];
                c_af  = sr1[4];
                c_zf  = sr1[6];
                c_sf  = sr1[7];
                c_of  = sr1[11];
            end
            OP_INC, OP_ADD: begin
                c_res = (arith[31:0] & msk) | (sr1 & ~msk);
                f_val = arith[31:0];
                c_cf  = bit_n(arith, alu1_op_size);
                c_af  = ar_x[4] ^ ar_y[4] ^ arith[4];
                c_of  = (ar_xm == ar_ym) && (ar_rm != ar_xm);
            end
            OP_STR: begin
                c_res = DF_in ? (sr1 - str_step) : (sr1 + str_step);
                c_std = 1'b0;
            end
            OP_CMP: begin
                c_res = sr1;
                f_val = arith[31:0];
                c_cf  = bit_n(arith, alu1_op_size);
                c_af  = ar_x[4] ^ ar_y[4] ^ arith[4];
                c_of  = (ar_xm != ar_ym) && (ar_rm != ar_xm);
            end
            OP_DAA: begin
                c_res = {eax[31:8], daa_2};
                f_val = {24'd0, daa_2};
                f_sz  = 2'b00;
                c_cf  = daa_hi;
                c_af  = daa_lo;
            end
            default: c_err = 1'b1;
        endcase

        if (c_std) begin
            c_zf = ((f_val & size_mask(f_sz)) == 32'd0);
            c_sf = msb_n(f_val, f_sz);
            c_pf = ~^f_val[7:0];
        end

        if (alu1_op_size == 2'b11) begin
            c_err = 1'b1;
        end
        if (c_err) begin
            c_res      = '0;
            c_cf       = 1'b0;
            c_pf       = 1'b0;
            c_af       = 1'b0;
            c_zf       = 1'b0;
            c_sf       = 1'b0;
            c_of       = 1'b0;
            c_ldf      = '0;
            c_go_shift = 1'b0;
        end
        c_flags = {c_of, c_sf, c_zf, c_af, c_pf, c_cf};
    end

    // One iteration of the shifter; the extra low bit of w_ar catches the last bit out
    logic [5:0]         step;
    logic [31:0]        msk_q, sh_next, sh_res;
    logic [32:0]        w_l;
    logic signed [32:0] w_ar;
    logic               cf_next, sh_sf, sh_zf, sh_pf, sh_of;

    always_comb begin
        step  = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
        msk_q = size_mask(sz_q);
        w_l   = {1'b0, sh_q} << step;
        w_ar  = $signed({sext_n(sh_q, sz_q), 1'b0}) >>> step;
        if (sar_q) begin
            sh_next = w_ar[32:1] & msk_q;
            cf_next = w_ar[0];
        end else begin
            sh_next = w_l[31:0] & msk_q;
            cf_next = bit_n(w_l, sz_q);
        end
        sh_res = sh_next | (hi_q & ~msk_q);
        sh_sf  = msb_n(sh_next, sz_q);
        sh_zf  = (sh_next == 32'd0);
        sh_pf  = ~^sh_next[7:0];
        sh_of  = sar_q ? 1'b0 : (sh_sf ^ cf_next);
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        ldf_d   = ldf_q;
        err_d   = err_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        sz_d    = sz_q;
        sar_d   = sar_q;
        ldsh_d  = ldsh_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (c_go_shift) begin
                        state_d = SHIFT;
                        rem_d   = {1'b0, sr2[4:0]};
                        sh_d    = sr1 & msk;
                        hi_d    = sr1;
                        sz_d    = alu1_op_size;
                        sar_d   = alu1_op[0];
                        ldsh_d  = ld_flag_in;
                    end else begin
                        state_d = DONE;
                        res_d   = c_res;
                        flags_d = c_flags;
                        ldf_d   = c_ldf;
                        err_d   = c_err;
                    end
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                rem_d = rem_q - step;
                if (rem_q == step) begin
                    state_d = DONE;
                    res_d   = sh_res;
                    flags_d = {sh_of, sh_sf, sh_zf, 1'b0, sh_pf, cf_next};
                    ldf_d   = ldsh_q;
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
            ldf_q   <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            sz_q    <= '0;
            sar_q   <= 1'b0;
            ldsh_q  <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            ldf_q   <= ldf_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            hi_q    <= hi_d;
            sz_q    <= sz_d;
            sar_q   <= sar_d;
            ldsh_q  <= ldsh_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign alu_res1    = res_q;
    assign alu1_flags  = flags_q;
    assign ld_flag_out = ldf_q;
    assign out_err     = err_q;

endmodule
